// File: rtl/accel_pkg.sv
// Shared definitions between the host loader and the accelerator core.
// LOADER_CHECKSUM_EN adds the CHECK state used for load trailers.
package accel_pkg;

    localparam int NUM_SIZE_DEF = 16;
    localparam int INSTR_W_DEF  = 32;
    localparam int ADDR_LEN_DEF = 5;

    localparam logic [3:0] CMD_LOAD_INSTR = 4'd1;
    localparam logic [3:0] CMD_LOAD_DATA  = 4'd2;
    localparam logic [3:0] CMD_RUN        = 4'd3;
    localparam logic [3:0] CMD_READ_DATA  = 4'd4;

    localparam int HDR_CMD_MSB  = 31;
    localparam int HDR_CMD_LSB  = 28;
    localparam int HDR_CNT_MSB  = 27;
    localparam int HDR_CNT_LSB  = 16;
    localparam int HDR_BASE_LSB = 0;
    localparam int CNT_W        = HDR_CNT_MSB - HDR_CNT_LSB + 1;
    localparam int CKSUM_W      = 16;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD_I, ST_LOAD_D, ST_CHECK, ST_CLEAR, ST_RUN, ST_READ
    } loader_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD_I, ST_LOAD_D, ST_CLEAR, ST_RUN, ST_READ
    } loader_state_e;
`endif

endpackage

// File: rtl/out_skid_reg.sv
// One-entry registered valid/ready stage for the readback stream.
module out_skid_reg
    import accel_pkg::*;
#(
    parameter int W = NUM_SIZE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/host_loader.sv
// Host front end: loads instruction/data memories, runs the core, reads data back.
// Define LOADER_CHECKSUM_EN to require a checksum trailer after every load.
//
// state   | meaning
// IDLE    | waiting for a header word
// LOAD_I  | writing payload words into the instruction store
// LOAD_D  | writing payload words into data memory
// CHECK   | comparing the trailer against the payload sum (LOADER_CHECKSUM_EN only)
// CLEAR   | one-cycle clear of core pc/halted
// RUN     | core executing until halted
// READ    | streaming data-memory words to the host
module host_loader
    import accel_pkg::*;
#(
    parameter int NUM_SIZE = NUM_SIZE_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_SIZE-1:0] out_data,
    output logic                instr_we,
    output logic [ADDR_LEN-1:0] instr_addr,
    output logic [INSTR_W-1:0]  instr_wdata,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [NUM_SIZE-1:0] mem_wdata,
    output logic [ADDR_LEN-1:0] mem_raddr,
    input  logic [NUM_SIZE-1:0] mem_rdata,
    output logic                acc_clear,
    output logic                acc_run,
    input  logic                halted,
    output logic                busy,
    output logic                error
);

    loader_state_e       state, state_nxt;
    logic [CNT_W-1:0]    remain;
    logic [ADDR_LEN-1:0] ptr;
    logic [3:0]          hdr_cmd;
    logic [CNT_W-1:0]    hdr_cnt;
    logic [ADDR_LEN-1:0] hdr_base;
    logic                last_word, push, skid_ready, bad_cmd, hdr_hs, load_hs;

    assign hdr_cmd   = in_data[HDR_CMD_MSB:HDR_CMD_LSB];
    assign hdr_cnt   = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
    assign hdr_base  = in_data[HDR_BASE_LSB +: ADDR_LEN];
    assign last_word = (remain == CNT_W'(1));
    assign busy      = (state != ST_IDLE);
    assign mem_raddr = ptr;
    assign hdr_hs    = (state == ST_IDLE) && in_valid && in_ready;
    assign load_hs   = ((state == ST_LOAD_I) || (state == ST_LOAD_D)) && in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        acc_clear = 1'b0;
        acc_run   = 1'b0;
        push      = 1'b0;
        bad_cmd   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    case (hdr_cmd)
                        CMD_LOAD_INSTR: if (hdr_cnt != '0) state_nxt = ST_LOAD_I;
                        CMD_LOAD_DATA:  if (hdr_cnt != '0) state_nxt = ST_LOAD_D;
                        CMD_RUN:        state_nxt = ST_CLEAR;
                        CMD_READ_DATA:  if (hdr_cnt != '0) state_nxt = ST_READ;
                        default:        bad_cmd = 1'b1;
                    endcase
                end
            end
            ST_LOAD_I, ST_LOAD_D: begin
                in_ready = !rst;
                if (in_valid && !rst && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                in_ready = !rst;
                if (in_valid && !rst) state_nxt = ST_IDLE;
            end
`endif
            ST_CLEAR: begin
                acc_clear = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                acc_run = 1'b1;
                if (halted) state_nxt = ST_IDLE;
            end
            ST_READ: begin
                // Issue reads while words remain; leave once the last one drains.
                if (remain != '0)                 push      = skid_ready;
                else if (out_valid && out_ready)  state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [CKSUM_W-1:0] cksum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            remain      <= '0;
            ptr         <= '0;
            instr_we    <= 1'b0;
            instr_addr  <= '0;
            instr_wdata <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cksum       <= '0;
`endif
        end else begin
            instr_we <= 1'b0;
            mem_we   <= 1'b0;
            if (bad_cmd) error <= 1'b1;
            if (hdr_hs) begin
                remain <= hdr_cnt;
                ptr    <= hdr_base;
`ifdef LOADER_CHECKSUM_EN
                cksum  <= '0;
`endif
            end
            if (load_hs) begin
                if (state == ST_LOAD_I) begin
                    instr_we    <= 1'b1;
                    instr_addr  <= ptr;
                    instr_wdata <= in_data[INSTR_W-1:0];
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= in_data[NUM_SIZE-1:0];
                end
                ptr    <= ptr + ADDR_LEN'(1);
                remain <= remain - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                cksum  <= cksum + in_data[CKSUM_W-1:0];
`endif
            end
            if (push) begin
                ptr    <= ptr + ADDR_LEN'(1);
                remain <= remain - CNT_W'(1);
            end
`ifdef LOADER_CHECKSUM_EN
            if ((state == ST_CHECK) && in_valid && in_ready && (in_data[CKSUM_W-1:0] != cksum))
                error <= 1'b1;
`endif
        end
    end

    out_skid_reg #(.W(NUM_SIZE)) u_out_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_ready  (skid_ready),
        .in_data   (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule
